// File: rtl/insn_fetch_ctrl.sv
// ============================================================================
// Module      : insn_fetch_ctrl
// Description : Instruction fetch sequencer. It owns the PC, buffers {insn, pc}
//               pairs and hands them to decode over a valid/ready interface.
//               Optional macro FETCH_PERF_CNT_EN adds fetch and stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module insn_fetch_ctrl #(
   parameter int          ADDR_W   = 10,
   parameter int          DEPTH    = 2,
   parameter int unsigned RESET_PC = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              halt,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [ADDR_W-1:0] pc_out,
   input  logic [31:0]       insn_in,
   output logic              insn_valid,
   output logic [31:0]       insn_data,
   output logic [ADDR_W-1:0] insn_pc,
   input  logic              insn_ready,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0]       fetch_cnt,
   output logic [31:0]       stall_cnt,
`endif
   output logic              busy
);

   localparam int                c_ptr_w    = $clog2(DEPTH);
   localparam int                c_cnt_w    = c_ptr_w + 1;
   localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(DEPTH);
   localparam logic [ADDR_W-1:0] c_reset_pc = ADDR_W'(RESET_PC);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [ADDR_W-1:0]   r_pc;
   logic [31:0]         r_buf_insn [DEPTH];
   logic [ADDR_W-1:0]   r_buf_pc   [DEPTH];
   logic [c_ptr_w-1:0]  r_wr_ptr;
   logic [c_ptr_w-1:0]  r_rd_ptr;
   logic [c_cnt_w-1:0]  r_count;
   logic                w_push;
   logic                w_pop;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE, S_HALT: if (start && !halt) w_state_next = S_RUN;
         S_RUN:          if (halt)           w_state_next = S_HALT;
         default:                            w_state_next = S_IDLE;
      endcase
   end

   assign insn_valid = (r_count != '0);
   assign w_pop      = insn_valid && insn_ready;
   // A full buffer still accepts a fetch when the head leaves in the same cycle.
   assign w_push     = (r_state == S_RUN) && !redirect_valid &&
                       ((r_count != c_depth) || w_pop);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_pc     <= c_reset_pc;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_buf_insn[i] <= '0;
            r_buf_pc[i]   <= '0;
         end
      end else begin
         r_state <= w_state_next;
         if (redirect_valid) begin
            r_pc     <= redirect_pc;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_push) begin
               r_buf_insn[r_wr_ptr] <= insn_in;
               r_buf_pc[r_wr_ptr]   <= r_pc;
               r_wr_ptr             <= r_wr_ptr + c_ptr_w'(1);
               r_pc                 <= r_pc + ADDR_W'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            if (w_push && !w_pop)      r_count <= r_count + c_cnt_w'(1);
            else if (!w_push && w_pop) r_count <= r_count - c_cnt_w'(1);
         end
      end
   end

   assign pc_out    = r_pc;
   assign insn_data = r_buf_insn[r_rd_ptr];
   assign insn_pc   = r_buf_pc[r_rd_ptr];
   assign busy      = (r_state == S_RUN);

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_fetch_cnt;
   logic [31:0] r_stall_cnt;
   logic        w_stall;

   assign w_stall = (r_state == S_RUN) && (r_count == c_depth) && !w_pop;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_fetch_cnt <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (w_push && (r_fetch_cnt != 32'hFFFF_FFFF))  r_fetch_cnt <= r_fetch_cnt + 32'd1;
         if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign fetch_cnt = r_fetch_cnt;
   assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_insn_fetch_ctrl.sv
// ============================================================================
// Module      : tb_insn_fetch_ctrl
// Description : Directed scoreboard bench for insn_fetch_ctrl (DEPTH=2, ADDR_W=10).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_insn_fetch_ctrl;

   localparam int ADDR_W = 10;
   localparam int DEPTH  = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic              halt;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic [ADDR_W-1:0] pc_out;
   logic [31:0]       insn_in;
   logic              insn_valid;
   logic [31:0]       insn_data;
   logic [ADDR_W-1:0] insn_pc;
   logic              insn_ready;
   logic              busy;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0]       fetch_cnt;
   logic [31:0]       stall_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int n_pops   = 0;
   logic [ADDR_W-1:0] exp_q [$];

   always #5 clk = ~clk;

   insn_fetch_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(0)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .halt           (halt),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .pc_out         (pc_out),
      .insn_in        (insn_in),
      .insn_valid     (insn_valid),
      .insn_data      (insn_data),
      .insn_pc        (insn_pc),
      .insn_ready     (insn_ready),
`ifdef FETCH_PERF_CNT_EN
      .fetch_cnt      (fetch_cnt),
      .stall_cnt      (stall_cnt),
`endif
      .busy           (busy)
   );

   // Memory image: every word is a distinct function of its index.
   function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] p);
      return {p, 6'h2B, 6'h00, p} ^ 32'h0F0F_1234;
   endfunction

   always_comb insn_in = mem_word(pc_out);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [ADDR_W-1:0] first, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(first + ADDR_W'(i));
   endtask

   // Score any handshake that will complete at the coming edge, then advance.
   task automatic tick();
      logic [ADDR_W-1:0] e_pc;
      if (insn_valid === 1'b1 && insn_ready === 1'b1) begin
         chk("pop_expected", {31'd0, exp_q.size() != 0}, 32'd1);
         if (exp_q.size() != 0) begin
            e_pc = exp_q.pop_front();
            n_pops++;
            chk("pop_pc", {22'd0, insn_pc}, {22'd0, e_pc});
            chk("pop_data", insn_data, mem_word(e_pc));
         end
      end
      if (redirect_valid || !rst_n) exp_q.delete();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
      redirect_pc = '0; insn_ready = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      chk("rst_pc_out", {22'd0, pc_out}, 32'd0);
      chk("rst_valid", {31'd0, insn_valid}, 32'd0);
      chk("rst_data", insn_data, 32'd0);
      chk("rst_insn_pc", {22'd0, insn_pc}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);

      // Streaming fetch with decode always ready
      push_exp(10'h000, 12);
      start = 1'b1; insn_ready = 1'b1;
      tick();
      start = 1'b0;
      chk("start_busy", {31'd0, busy}, 32'd1);
      chk("start_pc", {22'd0, pc_out}, 32'd0);
      chk("start_valid", {31'd0, insn_valid}, 32'd0);
      tick();
      chk("first_pc", {22'd0, pc_out}, 32'd1);
      chk("first_valid", {31'd0, insn_valid}, 32'd1);
      chk("first_insn_pc", {22'd0, insn_pc}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stream_pc", {22'd0, pc_out}, 32'(2 + i));
      end

      // Decode stall: buffer fills, PC freezes, head holds
      insn_ready = 1'b0;
      repeat (4) tick();
      chk("stall_pc", {22'd0, pc_out}, 32'd7);
      chk("stall_valid", {31'd0, insn_valid}, 32'd1);
      chk("stall_head", {22'd0, insn_pc}, 32'd5);
      insn_ready = 1'b1;
      repeat (3) tick();
      chk("resume_pc", {22'd0, pc_out}, 32'd10);
      chk("resume_head", {22'd0, insn_pc}, 32'd8);

      // Redirect with two entries buffered
      insn_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 10'h200;
      tick();
      redirect_valid = 1'b0;
      chk("redir_valid", {31'd0, insn_valid}, 32'd0);
      chk("redir_pc", {22'd0, pc_out}, 32'h200);
      push_exp(10'h200, 4);
      insn_ready = 1'b1;
      tick();
      chk("redir_first_valid", {31'd0, insn_valid}, 32'd1);
      chk("redir_first_pc", {22'd0, insn_pc}, 32'h200);
      tick(); tick();

      // Redirect to the last index: PC wraps to zero
      insn_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 10'h3FF;
      tick();
      redirect_valid = 1'b0;
      push_exp(10'h3FF, 4);
      insn_ready = 1'b1;
      tick();
      chk("wrap_head0", {22'd0, insn_pc}, 32'h3FF);
      tick();
      chk("wrap_head1", {22'd0, insn_pc}, 32'h000);
      tick();

      // Halt with a full buffer, then drain
      insn_ready = 1'b0;
      tick(); tick();
      chk("full_pc", {22'd0, pc_out}, 32'd3);
      halt = 1'b1;
      tick();
      halt = 1'b0;
      chk("halt_busy", {31'd0, busy}, 32'd0);
      insn_ready = 1'b1;
      tick(); tick();
      chk("drained_valid", {31'd0, insn_valid}, 32'd0);
      chk("drained_pc", {22'd0, pc_out}, 32'd3);
      tick();
      chk("halt_pc_frozen", {22'd0, pc_out}, 32'd3);

      // start and halt together: halt wins
      start = 1'b1; halt = 1'b1;
      tick();
      start = 1'b0; halt = 1'b0;
      chk("start_halt_busy", {31'd0, busy}, 32'd0);
      tick();
      chk("start_halt_pc", {22'd0, pc_out}, 32'd3);
      chk("start_halt_valid", {31'd0, insn_valid}, 32'd0);

      // Restart resumes at the frozen PC
      push_exp(10'h003, 3);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("restart_busy", {31'd0, busy}, 32'd1);
      chk("restart_pc", {22'd0, pc_out}, 32'd3);
      tick();
      chk("restart_valid", {31'd0, insn_valid}, 32'd1);
      chk("restart_head", {22'd0, insn_pc}, 32'd3);
      tick(); tick();

      // Reset in the middle of a run with a full buffer
      insn_ready = 1'b0;
      tick(); tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("midrst_valid", {31'd0, insn_valid}, 32'd0);
      chk("midrst_pc", {22'd0, pc_out}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_insn_pc", {22'd0, insn_pc}, 32'd0);
      chk("midrst_data", insn_data, 32'd0);

`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetch_rst", fetch_cnt, 32'd0);
      chk("perf_stall_rst", stall_cnt, 32'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      chk("perf_fetch", fetch_cnt, 32'd2);
      chk("perf_stall", stall_cnt, 32'd2);
`endif

      chk("pop_total", 32'(n_pops), 32'd16);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
